// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pkg : shared constants and FSM encoding for the memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int   AW         = 10;
  localparam int   DW         = 16;
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  typedef enum logic [0:0] {
    P1_PRI   = 1'b0,
    FORCE_P0 = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arb_pick : combinational grant decision, data port wins unless forced
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       p0_req,
  input  logic       p1_req,
  input  arb_state_t state,
  output logic       gnt0,
  output logic       gnt1
);

  always_comb begin
    gnt1 = 1'b0;
    gnt0 = 1'b0;
    if (p1_req && !(p0_req && (state == FORCE_P0))) begin
      gnt1 = 1'b1;
    end else if (p0_req) begin
      gnt0 = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_port_arbiter : two-port pipelined arbiter in front of a 1-cycle sync RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = mem_arb_pkg::AW,
  parameter int DW         = mem_arb_pkg::DW,
  parameter int MAX_CONSEC = 4
) (
  input  logic          clka,
  input  logic          reset_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_wea,
  output logic [AW-1:0] mem_addra,
  output logic [DW-1:0] mem_dina,
  input  logic [DW-1:0] mem_douta
);

  localparam logic [3:0] c_max = 4'(MAX_CONSEC);

  arb_state_t    r_state;
  logic [3:0]    r_cnt;
  logic          r_tag_vld;
  logic          r_tag_port;
  logic          w_gnt0;
  logic          w_gnt1;
  logic [3:0]    w_cnt_nxt;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  mem_arb_pick u_pick (
    .p0_req (p0_req),
    .p1_req (p1_req),
    .state  (r_state),
    .gnt0   (w_gnt0),
    .gnt1   (w_gnt1)
  );

  assign p0_gnt   = w_gnt0;
  assign p1_gnt   = w_gnt1;
  assign p0_rdata = mem_douta;
  assign p1_rdata = mem_douta;

  always_comb begin
    w_we    = w_gnt1 ? p1_we    : p0_we;
    w_addr  = w_gnt1 ? p1_addr  : p0_addr;
    w_wdata = w_gnt1 ? p1_wdata : p0_wdata;
  end

  // Counts data-port wins over a waiting fetch; any fetch grant or idle fetch clears it.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (p0_req && w_gnt1) begin
      w_cnt_nxt = (r_cnt >= c_max) ? c_max : (r_cnt + 4'd1);
    end
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= P1_PRI;
      r_cnt      <= 4'd0;
      r_tag_vld  <= 1'b0;
      r_tag_port <= PORT_FETCH;
      p0_rvalid  <= 1'b0;
      p1_rvalid  <= 1'b0;
      mem_wea    <= 1'b0;
      mem_addra  <= '0;
      mem_dina   <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      case (r_state)
        P1_PRI:   if (w_cnt_nxt == c_max) r_state <= FORCE_P0;
        FORCE_P0: if (w_gnt0 || !p0_req)  r_state <= P1_PRI;
        default:  r_state <= P1_PRI;
      endcase

      if (w_gnt0 || w_gnt1) begin
        mem_wea   <= w_we;
        mem_addra <= w_addr;
        mem_dina  <= w_wdata;
      end else begin
        mem_wea <= 1'b0;
      end

      // Tag travels one stage behind the issue register, matching RAM latency.
      r_tag_vld  <= (w_gnt0 || w_gnt1) && !w_we;
      r_tag_port <= w_gnt1 ? PORT_DATA : PORT_FETCH;
      p0_rvalid  <= r_tag_vld && (r_tag_port == PORT_FETCH);
      p1_rvalid  <= r_tag_vld && (r_tag_port == PORT_DATA);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter : directed + randomized checks against a behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int MAX_CONSEC = 4;

  logic        clka = 1'b0;
  logic        reset_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [9:0]  p0_addr, p1_addr;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata;
  logic        mem_wea;
  logic [9:0]  mem_addra;
  logic [15:0] mem_dina, mem_douta;

  always #5 clka = ~clka;

  mem_port_arbiter #(.AW(10), .DW(16), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clka(clka), .reset_n(reset_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
    .mem_douta(mem_douta)
  );

  // Block memory: one-cycle synchronous read.
  logic [15:0] ram [0:1023];
  always @(posedge clka) begin
    if (mem_wea) ram[mem_addra] <= mem_dina;
    mem_douta <= ram[mem_addra];
  end

  int total  = 0;
  int passes = 0;

  // Reference model: memory image at accept time, returns due two edges later.
  typedef struct packed {
    logic        vld;
    logic        port;
    logic [15:0] data;
  } ret_t;

  logic [15:0] ref_mem [0:1023];
  int          starve;
  ret_t        ret_issued, ret_due;
  logic        exp_wea;
  logic [9:0]  exp_addr;
  logic [15:0] exp_din;
  logic        last_g0, last_g1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    starve     = 0;
    ret_issued = '0;
    ret_due    = '0;
    exp_wea    = 1'b0;
    exp_addr   = '0;
    exp_din    = '0;
  endtask

  // Called just after a rising edge; drives one cycle and checks it.
  task automatic step(input logic a_req, input logic a_we, input logic [9:0] a_addr,
                      input logic [15:0] a_wd, input logic b_req, input logic b_we,
                      input logic [9:0] b_addr, input logic [15:0] b_wd);
    logic        e0, e1, we;
    logic [9:0]  addr;
    logic [15:0] wd;
    p0_req = a_req; p0_we = a_we; p0_addr = a_addr; p0_wdata = a_wd;
    p1_req = b_req; p1_we = b_we; p1_addr = b_addr; p1_wdata = b_wd;
    @(negedge clka);
    e1 = b_req && !(a_req && (starve >= MAX_CONSEC));
    e0 = a_req && !e1;
    chk("p0_gnt", p0_gnt, e0);
    chk("p1_gnt", p1_gnt, e1);
    chk("mem_wea", mem_wea, exp_wea);
    chk("mem_addra", mem_addra, exp_addr);
    chk("mem_dina", mem_dina, exp_din);
    chk("p0_rvalid", p0_rvalid, ret_due.vld && !ret_due.port);
    chk("p1_rvalid", p1_rvalid, ret_due.vld && ret_due.port);
    if (ret_due.vld)
      chk(ret_due.port ? "p1_rdata" : "p0_rdata",
          ret_due.port ? p1_rdata : p0_rdata, ret_due.data);
    last_g0 = e0;
    last_g1 = e1;
    @(posedge clka);
    ret_due    = ret_issued;
    ret_issued = '0;
    if (e0 || e1) begin
      we   = e1 ? b_we : a_we;
      addr = e1 ? b_addr : a_addr;
      wd   = e1 ? b_wd : a_wd;
      exp_wea  = we;
      exp_addr = addr;
      exp_din  = wd;
      if (we) ref_mem[addr] = wd;
      else    ret_issued = {1'b1, e1, ref_mem[addr]};
    end else begin
      exp_wea = 1'b0;
    end
    if (a_req && e1) starve = (starve + 1 > MAX_CONSEC) ? MAX_CONSEC : starve + 1;
    else             starve = 0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [9:0]  seq;
  logic        ra_req, ra_we, rb_req, rb_we;
  logic [9:0]  ra_addr, rb_addr;
  logic [15:0] ra_wd, rb_wd;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clka);
    chk("rst_mem_wea", mem_wea, 0);
    chk("rst_mem_addra", mem_addra, 0);
    chk("rst_mem_dina", mem_dina, 0);
    chk("rst_p0_rvalid", p0_rvalid, 0);
    chk("rst_p1_rvalid", p1_rvalid, 0);
    reset_n = 1'b1;
    @(posedge clka); #1;

    // Single write then read on port 1
    step(0, 0, 0, 0, 1, 1, 10'd0, 16'hDEAD);
    step(0, 0, 0, 0, 1, 0, 10'd0, 16'h0);
    idle(3);

    // Mixed ports
    step(1, 1, 10'd1, 16'hBEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 10'd2, 16'hABCD);
    step(1, 0, 10'd2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 10'd1, 0);
    idle(3);

    // Contention: both read continuously
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 10'd1, 0, 1, 0, 10'd2, 0);
      seq[i] = last_g1;
    end
    chk("contention_seq", seq, 10'b0111101111);
    idle(3);

    // Back-to-back reads on port 1
    step(0, 0, 0, 0, 1, 0, 10'd0, 0);
    step(0, 0, 0, 0, 1, 0, 10'd1, 0);
    step(0, 0, 0, 0, 1, 0, 10'd2, 0);
    idle(3);

    // Reset while a read is in flight
    step(0, 0, 0, 0, 1, 0, 10'd0, 0);
    p1_req = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_mem_wea", mem_wea, 0);
    chk("midrst_mem_addra", mem_addra, 0);
    chk("midrst_p1_rvalid", p1_rvalid, 0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      chk("midrst_hold_p0_rvalid", p0_rvalid, 0);
      chk("midrst_hold_p1_rvalid", p1_rvalid, 0);
    end
    reset_n = 1'b1;
    @(posedge clka); #1;
    step(1, 0, 10'd5, 0, 0, 0, 0, 0);
    idle(3);

    // Write produces no rvalid
    step(1, 1, 10'd5, 16'h1234, 0, 0, 0, 0);
    idle(3);

    // Randomized traffic, requests held until granted
    ra_req = 0; rb_req = 0;
    ra_we = 0; rb_we = 0; ra_addr = 0; rb_addr = 0; ra_wd = 0; rb_wd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!ra_req || last_g0) begin
        ra_req  = ($urandom_range(0, 3) != 0);
        ra_we   = ($urandom_range(0, 2) == 0);
        ra_addr = 10'($urandom_range(0, 15));
        ra_wd   = 16'($urandom);
      end
      if (!rb_req || last_g1) begin
        rb_req  = ($urandom_range(0, 3) != 0);
        rb_we   = ($urandom_range(0, 2) == 0);
        rb_addr = 10'($urandom_range(0, 15));
        rb_wd   = 16'($urandom);
      end
      last_g0 = 0; last_g1 = 0;
      step(ra_req, ra_we, ra_addr, ra_wd, rb_req, rb_we, rb_addr, rb_wd);
    end
    idle(3);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 1K x 16 block memory (blockmemory16kx1: clka, wea, addra[9:0], dina[15:0], douta[15:0], one-cycle synchronous read) between two requesters.
- Port 0 is the instruction-fetch path; port 1 is the load/store data path.
- Port 1 has fixed priority, with a starvation limit that guarantees fetch progress.
- Pipelined: one access accepted per cycle. Read data is returned with rvalid, tagged to the originating port.

Parameters:
- AW, 10, memory address width
- DW, 16, memory data width
- MAX_CONSEC, 4, maximum consecutive port-1 grants while port 0 is waiting; range 1..15

Ports:
- clka  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  reset, asynchronous and active-low
- p0_req  in  1  port 0 access request
- p0_we  in  1  port 0 write enable; 0 = read
- p0_addr  in  AW  port 0 address
- p0_wdata  in  DW  port 0 write data
- p0_gnt  out  1  port 0 request accepted this cycle
- p0_rvalid  out  1  port 0 read data valid
- p0_rdata  out  DW  port 0 read data
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1
- mem_wea  out  1  to memory wea
- mem_addra  out  AW  to memory addra
- mem_dina  out  DW  to memory dina
- mem_douta  in  DW  from memory douta

Behaviour:
- Reset (async assert, sync deassert):
  - Outputs: mem_wea=0, mem_addra=0, mem_dina=0, p0_rvalid=p1_rvalid=0.
  - Internal state: starvation counter=0, read-tag pipeline cleared.
  - Reads in flight when reset asserts are discarded; no rvalid follows them.
- Handshake:
  - A requester holds req, we, addr and wdata stable until gnt.
  - Transfer occurs on the edge where req and gnt are both high.
  - gnt is combinational from req and the arbitration state. At most one gnt is high per cycle.
- Arbitration (each cycle):
  - Only p1_req: grant p1.
  - Only p0_req: grant p0.
  - Both: grant p1 unless the starvation counter equals MAX_CONSEC; in that case grant p0.
- Starvation counter:
  - Increments on each p1 grant made while p0_req is high.
  - Clears on any p0 grant, or on any cycle where p0_req is low.
  - Saturates at MAX_CONSEC.
- Issue stage (registered):
  - On an accepting edge E0, mem_addra, mem_dina and mem_wea load from the winner.
  - If there is no grant, mem_wea loads 0; mem_addra and mem_dina hold their values.
  - The memory samples at edge E1.
- Read return:
  - A read accepted at E0 produces its rvalid for exactly one cycle, from E1 to E2, on the granting port only.
  - rdata equals mem_douta, combinational passthrough, during that cycle.
  - The tag pipeline is a 2-bit register {valid, port}, loaded at E0 and raised as rvalid after E1.
- Writes: produce gnt only, never rvalid. mem_wea is high for exactly one cycle per accepted write.
- Throughput and ordering:
  - Back-to-back accepts every cycle are allowed.
  - Returns are in issue order; read-after-write to the same address returns the new data.
- rdata values: both pX_rdata carry mem_douta at all times and are meaningful only while pX_rvalid is high.
- FSM (starvation control):
  - States: P1_PRI, FORCE_P0.
  - P1_PRI moves to FORCE_P0 when the counter reaches MAX_CONSEC and p0_req is high.
  - FORCE_P0 moves to P1_PRI after the p0 grant, or when p0_req drops.

Decomposition:
- Shared package mem_arb_pkg: AW/DW constants, port-ID constants (PORT_FETCH=0, PORT_DATA=1), FSM state encoding.
- One sub-module, mem_arb_pick: combinational priority and starvation decision producing gnt0/gnt1. Registers stay in the top level.

Test Plan:
- Single write then read, port 1:
  - Write addr 0 = 57005 (0xDEAD); next cycle read addr 0.
  - p1_gnt high both cycles; p1_rvalid high one cycle, 2 edges after the read accept, with p1_rdata=57005; p0_rvalid stays 0.
- Mixed ports:
  - Port 0 writes addr 1 = 48879 (0xBEEF); port 1 writes addr 2 = 43981 (0xABCD).
  - Port 0 reads addr 2, returning 43981 on p0_rvalid; port 1 reads addr 1, returning 48879 on p1_rvalid.
- Contention:
  - p0_req and p1_req held high; both ports read distinct addresses continuously.
  - With MAX_CONSEC=4, the grant sequence is p1,p1,p1,p1,p0,p1,p1,p1,p1,p0, and every returned rdata matches its port's address.
- Back-to-back pipelining:
  - Port 1 reads addresses 0,1,2 on consecutive cycles.
  - p1_rvalid stays high 3 consecutive cycles with rdata 57005, 48879, 43981.
- Reset mid-read:
  - Read accepted at E0; reset_n pulled low before E1.
  - No rvalid ever appears; mem_wea=0 immediately; after release, the first request is granted normally.
- Write produces no rvalid:
  - Port 0 write of 0x1234 to addr 5.
  - mem_wea high exactly one cycle with mem_addra=5 and mem_dina=0x1234; p0_rvalid stays 0.
